pong_button_cond: RTL and testbench

Input conditioning stage for the Pong controls. Takes raw, asynchronous, bouncy push-button levels from the board pins (player paddle up/down and switches). It delivers clean, synchronous, debounced levels plus single-cycle press/release strobes. The debounced levels drive the paddle controllers' up/down inputs directly; the strobes feed the game-state logic (serve/start).

---
 rtl/pong_button_cond.sv | 120 ++++++++++++
 tb/tb_pong_button_cond.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pong_button_cond.sv
// Button conditioning for the Pong controls: 2-flop synchronizer, per-channel debounce filter,
// registered press/release strobes. Optional auto-repeat on o_Press when PONG_BTN_REPEAT_EN is defined.
module pong_button_cond #(
    parameter int c_NUM_BTN        = 5,
    parameter int c_DEBOUNCE_LIMIT = 250000,
    parameter int c_ACTIVE_LOW     = 0,
    parameter int c_REPEAT_DELAY   = 12500000,
    parameter int c_REPEAT_PERIOD  = 2500000
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic [c_NUM_BTN-1:0] i_Btn,
    output logic [c_NUM_BTN-1:0] o_Btn,
    output logic [c_NUM_BTN-1:0] o_Press,
    output logic [c_NUM_BTN-1:0] o_Release
);

    localparam int c_CNT_W = $clog2(c_DEBOUNCE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_DEBOUNCE_LIMIT - 1);

    logic [c_NUM_BTN-1:0] w_Norm;
    logic [c_NUM_BTN-1:0] r_Sync1;
    logic [c_NUM_BTN-1:0] r_Sync2;

    assign w_Norm = (c_ACTIVE_LOW != 0) ? ~i_Btn : i_Btn;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_Sync1 <= '0;
            r_Sync2 <= '0;
        end else begin
            r_Sync1 <= w_Norm;
            r_Sync2 <= r_Sync1;
        end
    end

    for (genvar g = 0; g < c_NUM_BTN; g++) begin : g_chan
        logic [c_CNT_W-1:0] r_Cnt;
        logic               r_Stable;
        logic               r_Press;
        logic               r_Release;
        logic               w_Differ;
        logic               w_Accept;
        logic               w_Rise;
        logic               w_Fall;

        assign w_Differ = (r_Sync2[g] != r_Stable);
        assign w_Accept = w_Differ && (r_Cnt == c_CNT_LAST);
        assign w_Rise   = w_Accept && r_Sync2[g];
        assign w_Fall   = w_Accept && !r_Sync2[g];

        // Any single cycle of agreement restarts the count, so short bounces never reach the limit.
        always_ff @(posedge i_Clk or posedge i_Rst) begin
            if (i_Rst) begin
                r_Cnt     <= '0;
                r_Stable  <= 1'b0;
                r_Release <= 1'b0;
            end else begin
                r_Release <= w_Fall;
                if (!w_Differ) begin
                    r_Cnt <= '0;
                end else if (w_Accept) begin
                    r_Stable <= r_Sync2[g];
                    r_Cnt    <= '0;
                end else begin
                    r_Cnt <= r_Cnt + 1'b1;
                end
            end
        end

`ifdef PONG_BTN_REPEAT_EN
        localparam int c_RC_MAX = (c_REPEAT_DELAY > c_REPEAT_PERIOD) ? c_REPEAT_DELAY : c_REPEAT_PERIOD;
        localparam int c_RC_W   = $clog2(c_RC_MAX + 1);
        localparam logic [c_RC_W-1:0] c_RC_DELAY  = c_RC_W'(c_REPEAT_DELAY);
        localparam logic [c_RC_W-1:0] c_RC_PERIOD = c_RC_W'(c_REPEAT_PERIOD);

        logic [c_RC_W-1:0] r_Rc;
        logic [c_RC_W-1:0] w_RcNext;
        logic              r_Repeating;
        logic              w_RepHit;

        assign w_RcNext = r_Rc + 1'b1;
        assign w_RepHit = r_Stable && !w_Accept &&
                          (w_RcNext == (r_Repeating ? c_RC_PERIOD : c_RC_DELAY));

        // First repeat waits the long delay, later ones the short period; any level change restarts.
        always_ff @(posedge i_Clk or posedge i_Rst) begin
            if (i_Rst) begin
                r_Rc        <= '0;
                r_Repeating <= 1'b0;
                r_Press     <= 1'b0;
            end else begin
                r_Press <= w_Rise || w_RepHit;
                if (!r_Stable || w_Accept) begin
                    r_Rc        <= '0;
                    r_Repeating <= 1'b0;
                end else if (w_RepHit) begin
                    r_Rc        <= '0;
                    r_Repeating <= 1'b1;
                end else begin
                    r_Rc <= w_RcNext;
                end
            end
        end
`else
        always_ff @(posedge i_Clk or posedge i_Rst) begin
            if (i_Rst) begin
                r_Press <= 1'b0;
            end else begin
                r_Press <= w_Rise;
            end
        end
`endif

        assign o_Btn[g]     = r_Stable;
        assign o_Press[g]   = r_Press;
        assign o_Release[g] = r_Release;
    end

endmodule

// File: tb/tb_pong_button_cond.sv
// Directed bench for pong_button_cond: debounce limit 4, two channels, plus an active-low instance.
// Repeat expectations follow PONG_BTN_REPEAT_EN (delay 10, period 4) when that macro is defined.
module tb_pong_button_cond;

    logic       clock;
    logic       reset;
    logic [1:0] btnHigh;
    logic [1:0] btnLow;
    logic [1:0] outBtn;
    logic [1:0] outPress;
    logic [1:0] outRelease;
    logic [1:0] lowBtn;
    logic [1:0] lowPress;
    logic [1:0] lowRelease;

    int checkCount = 0;
    int errorCount = 0;
    int pressTotal = 0;
    int releaseTotal = 0;
    int lowPressTotal = 0;
    int lowReleaseTotal = 0;

    pong_button_cond #(
        .c_NUM_BTN(2), .c_DEBOUNCE_LIMIT(4), .c_ACTIVE_LOW(0),
        .c_REPEAT_DELAY(10), .c_REPEAT_PERIOD(4)
    ) dut (
        .i_Clk(clock), .i_Rst(reset), .i_Btn(btnHigh),
        .o_Btn(outBtn), .o_Press(outPress), .o_Release(outRelease)
    );

    pong_button_cond #(
        .c_NUM_BTN(2), .c_DEBOUNCE_LIMIT(4), .c_ACTIVE_LOW(1),
        .c_REPEAT_DELAY(10), .c_REPEAT_PERIOD(4)
    ) dutLow (
        .i_Clk(clock), .i_Rst(reset), .i_Btn(btnLow),
        .o_Btn(lowBtn), .o_Press(lowPress), .o_Release(lowRelease)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Running strobe totals sampled mid-cycle, so window checks can use snapshot differences.
    always @(negedge clock) begin
        pressTotal      = pressTotal + int'(outPress[0]);
        releaseTotal    = releaseTotal + int'(outRelease[0]);
        lowPressTotal   = lowPressTotal + int'(lowPress[0]) + int'(lowPress[1]);
        lowReleaseTotal = lowReleaseTotal + int'(lowRelease[0]) + int'(lowRelease[1]);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [1:0] high, input logic [1:0] low);
        btnHigh = high;
        btnLow  = low;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        applyStimulus(2'b00, 2'b11);
        stepCycles(3);
        reset = 1'b0;
        stepCycles(2);
    endtask

    function automatic logic expectPress(input int k);
`ifdef PONG_BTN_REPEAT_EN
        return (k == 5) || (k >= 15 && ((k - 15) % 4) == 0);
`else
        return (k == 5);
`endif
    endfunction

    int snapPress;
    int snapRelease;

    initial begin
        reset = 1'b1;
        applyStimulus(2'b00, 2'b11);
        stepCycles(3);
        checkOutput("reset_btn", {30'd0, outBtn}, 32'd0);
        checkOutput("reset_strobes", {28'd0, outPress, outRelease}, 32'd0);
        reset = 1'b0;
        stepCycles(2);

        // Clean press on channel 0
        applyStimulus(2'b01, 2'b11);
        stepCycles(5);
        checkOutput("clean_before_E5", {30'd0, outBtn}, 32'd0);
        stepCycles(1);
        checkOutput("clean_btn_E5", {30'd0, outBtn}, 32'd1);
        checkOutput("clean_press_E5", {30'd0, outPress}, 32'd1);
        stepCycles(1);
        checkOutput("clean_press_E6", {30'd0, outPress}, 32'd0);
        checkOutput("clean_btn_E6", {30'd0, outBtn}, 32'd1);

        // Bounce rejection
        applyReset();
        snapPress = pressTotal;
        snapRelease = releaseTotal;
        for (int p = 0; p < 8; p++) begin
            applyStimulus((p % 2 == 0) ? 2'b01 : 2'b00, 2'b11);
            stepCycles(3);
            checkOutput("bounce_btn", {30'd0, outBtn}, 32'd0);
        end
        checkOutput("bounce_no_press", pressTotal - snapPress, 32'd0);
        checkOutput("bounce_no_release", releaseTotal - snapRelease, 32'd0);
        applyStimulus(2'b01, 2'b11);
        stepCycles(5);
        checkOutput("hold_before_E5", {30'd0, outBtn}, 32'd0);
        stepCycles(1);
        checkOutput("hold_btn_E5", {30'd0, outBtn}, 32'd1);
        checkOutput("hold_press_E5", {30'd0, outPress}, 32'd1);

        // Simultaneous release on both channels
        applyReset();
        applyStimulus(2'b11, 2'b11);
        stepCycles(8);
        checkOutput("both_pressed", {30'd0, outBtn}, 32'd3);
        applyStimulus(2'b00, 2'b11);
        stepCycles(5);
        checkOutput("rel_before_E5", {30'd0, outRelease}, 32'd0);
        checkOutput("rel_btn_before_E5", {30'd0, outBtn}, 32'd3);
        stepCycles(1);
        checkOutput("rel_E5", {30'd0, outRelease}, 32'd3);
        checkOutput("rel_btn_E5", {30'd0, outBtn}, 32'd0);
        checkOutput("rel_press_E5", {30'd0, outPress}, 32'd0);
        stepCycles(1);
        checkOutput("rel_E6", {30'd0, outRelease}, 32'd0);

        // Reset asserted mid-count, button held through reset release
        applyReset();
        applyStimulus(2'b01, 2'b11);
        stepCycles(2);
        reset = 1'b1;
        #1;
        checkOutput("rst_async_outputs", {26'd0, outBtn, outPress, outRelease}, 32'd0);
        stepCycles(3);
        checkOutput("rst_held_outputs", {26'd0, outBtn, outPress, outRelease}, 32'd0);
        snapPress = pressTotal;
        reset = 1'b0;
        stepCycles(5);
        checkOutput("rst_before_E5", {30'd0, outBtn}, 32'd0);
        stepCycles(1);
        checkOutput("rst_btn_E5", {30'd0, outBtn}, 32'd1);
        checkOutput("rst_press_E5", {30'd0, outPress}, 32'd1);
        stepCycles(4);
        checkOutput("rst_one_press", pressTotal - snapPress, 32'd1);

        // Active-low instance: pins idle high, then channel 1 pulled low
        checkOutput("low_idle_btn", {30'd0, lowBtn}, 32'd0);
        checkOutput("low_idle_strobes", lowPressTotal + lowReleaseTotal, 32'd0);
        applyStimulus(btnHigh, 2'b01);
        stepCycles(5);
        checkOutput("low_before_E5", {30'd0, lowBtn}, 32'd0);
        stepCycles(1);
        checkOutput("low_btn_E5", {30'd0, lowBtn}, 32'd2);
        checkOutput("low_press_E5", {30'd0, lowPress}, 32'd2);
        stepCycles(1);
        checkOutput("low_press_E6", {30'd0, lowPress}, 32'd0);

        // Long hold: single press, or auto-repeat when enabled
        applyReset();
        applyStimulus(2'b01, 2'b11);
        for (int k = 0; k <= 34; k++) begin
            stepCycles(1);
            checkOutput($sformatf("hold_press_k%0d", k), {31'd0, outPress[0]}, {31'd0, expectPress(k)});
        end
        snapRelease = releaseTotal;
        applyStimulus(2'b00, 2'b11);
        stepCycles(6);
        checkOutput("long_release_strobe", {31'd0, outRelease[0]}, 32'd1);
        checkOutput("long_release_btn", {30'd0, outBtn}, 32'd0);
        snapPress = pressTotal;
        stepCycles(10);
        checkOutput("long_no_press_after", pressTotal - snapPress, 32'd0);
        checkOutput("long_one_release", releaseTotal - snapRelease, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
